checksum_trailer_appender: RTL and testbench
============================================

Name: checksum_trailer_appender

Overview:
Stream stage sitting directly upstream of the Fletcher checksum engine; also drives that engine's control inputs.
- Passes fixed-length packets of half-width words through to the output.
- Feeds every accepted word to the checksum engine, then appends the Width-bit checksum as two half-width trailer words.
- Used on the readout path so the host can verify each block.

Parameters:
Width, 32, checksum width; payload and trailer words are Width/2 bits (WidthHalf, derived localparam).
PacketWords, 256, payload words per packet (must be >= 1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  payload word valid
in_ready  out  1  payload word accepted when in_valid&&in_ready
in_data  in  WidthHalf  payload word
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts when out_valid&&out_ready
out_data  out  WidthHalf  payload or trailer word
out_last  out  1  marks final trailer word of packet
ck_rst  out  1  checksum engine synchronous reset
ck_en  out  1  checksum engine enable
ck_din  out  WidthHalf  checksum engine data
ck_dout  in  Width  checksum engine result

Behaviour:
- Clock is clk; reset is synchronous, active-high on rst.
- While rst is high:
  - out_valid=0, in_ready=0, ck_en=0, ck_rst=1 (combinational OR with rst).
  - Word counter cleared; state=PAYLOAD.
- Reset mid-packet discards the partial packet; no trailer is emitted.
- States: PAYLOAD, FLUSH, TRAIL_HI, TRAIL_LO.
- PAYLOAD:
  - Pass-through: out_valid=in_valid, in_ready=out_ready, out_data=in_data, out_last=0. Zero latency, no buffering.
  - On each transfer: ck_en=1, ck_din=in_data, counter++.
  - On the transfer where counter==PacketWords-1: counter cleared, go to FLUSH.
- FLUSH (exactly 1 cycle):
  - ck_en=1, ck_din=0, out_valid=0, in_ready=0.
  - Needed because the engine's B sum lags the A sum by one enable; the result is valid on ck_dout from the next cycle.
  - Go to TRAIL_HI.
- TRAIL_HI:
  - out_valid=1, out_data=ck_dout[Width-1:WidthHalf], in_ready=0, ck_en=0.
  - On accept, go to TRAIL_LO.
- TRAIL_LO:
  - out_valid=1, out_data=ck_dout[WidthHalf-1:0], out_last=1.
  - On accept: ck_rst=1 for that cycle, go to PAYLOAD.
- ck_en is never asserted outside PAYLOAD transfers and FLUSH, so ck_dout stays stable under arbitrary out_ready backpressure in the trailer states.
- The first word of the next packet can transfer on the cycle right after the TRAIL_LO accept; the engine has been cleared at that edge.
- Counter width: $clog2(PacketWords+1). No wrap within a packet.
- Trailer output is not registered; out_data in the trailer states follows ck_dout, which is itself registered.

Optional Feature:
CHECKSUM_TRAILER_LEN_EN
- Defined:
  - Adds input pkt_len [$clog2(PacketWords+1)-1:0], sampled in PAYLOAD when counter==0 and no packet is in progress.
  - The packet ends after pkt_len words.
  - pkt_len==0 goes straight from idle PAYLOAD to FLUSH with no payload words; the trailer is 0x0,0x0.
  - pkt_len>PacketWords is clamped to PacketWords.
- Undefined: length is fixed at PacketWords and there is no pkt_len port.

Decomposition:
- Shared package holds:
  - the state enum (PAYLOAD, FLUSH, TRAIL_HI, TRAIL_LO)
  - the WidthHalf derivation
  - the counter-width function
- No sub-module. The checksum engine is instantiated by the parent and wired through the ck_* ports, so this block stays testable with a behavioural engine model.

Test Plan:
- Width=16, PacketWords=2, in 0x01,0x02, out_ready=1 -> out 0x01,0x02, idle cycle, then 0x04, 0x03 (out_last=1).
- Width=16, PacketWords=2, in 0xFF,0xFF -> trailer 0x00, 0x00 (mod-255 fold); then next packet 0x01,0x02 -> trailer 0x04,0x03, proving engine reset.
- out_ready low 5 cycles during TRAIL_HI -> out_data held at 0x04, ck_en stays 0, then trailer completes correctly.
- rst asserted after first payload word -> no trailer emitted; next packet 0x01,0x02 gives trailer 0x04,0x03.
- Random in_valid/out_ready gaps over 100 packets of random data -> trailer matches reference Fletcher model; in_ready never high outside PAYLOAD.
- LEN_EN defined: pkt_len=0 -> trailer 0x00,0x00 with no payload; pkt_len=1 with 0x05 -> 0x05, then 0x05, 0x05.

Source files
------------

// File: rtl/checksum_trailer_appender_pkg.sv
// Shared types and sizing helpers for the checksum trailer appender.
// Holds the FSM state encoding, the half-width word derivation and the
// word-counter width function so every user sizes things the same way.
package checksum_trailer_appender_pkg;

  // Packet phases: pass payload, prime the engine, emit the two trailer words
  typedef enum logic [1:0] {
    PAYLOAD  = 2'd0,
    FLUSH    = 2'd1,
    TRAIL_HI = 2'd2,
    TRAIL_LO = 2'd3
  } state_t;

  // Payload and trailer words are half the checksum width
  function automatic int half_width(input int width);
    return width / 2;
  endfunction

  // Counter must be able to hold 0..words inclusive
  function automatic int cnt_width(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/checksum_trailer_appender.sv
// Purpose: pass fixed-length half-width packets through, feed each word to an
//   external Fletcher engine, then append its Width-bit result as two trailer words.
// Latency: payload is zero-latency pass-through; trailer follows after one idle
//   FLUSH cycle. Backpressure: in_ready mirrors out_ready during payload, is held
//   low from FLUSH through the trailer; the engine is frozen while the trailer stalls.
// Optional build macro CHECKSUM_TRAILER_LEN_EN adds a per-packet pkt_len input.
module checksum_trailer_appender
  import checksum_trailer_appender_pkg::*;
#(
  parameter  int Width       = 32,
  parameter  int PacketWords = 256,
  localparam int WidthHalf   = half_width(Width),
  localparam int CntW        = cnt_width(PacketWords)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CHECKSUM_TRAILER_LEN_EN
  input  logic [CntW-1:0]      pkt_len,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WidthHalf-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WidthHalf-1:0] out_data,
  output logic                 out_last,
  output logic                 ck_rst,
  output logic                 ck_en,
  output logic [WidthHalf-1:0] ck_din,
  input  logic [Width-1:0]     ck_dout
);

  state_t          state_q;
  state_t          state_d;
  logic [CntW-1:0] cnt_q;
  logic            in_xfer;
  logic            out_xfer;
  logic            last_word;
  logic            zero_len;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

`ifdef CHECKSUM_TRAILER_LEN_EN
  logic [CntW-1:0] len_q;
  logic [CntW-1:0] len_clamp;
  logic [CntW-1:0] len_eff;

  // Oversized requests are clamped to the maximum packet length
  assign len_clamp = (pkt_len > CntW'(PacketWords)) ? CntW'(PacketWords) : pkt_len;
  // The requested length is live only before the first word; afterwards the latched copy rules
  assign len_eff   = (cnt_q == '0) ? len_clamp : len_q;
  assign last_word = (cnt_q == (len_eff - CntW'(1)));
  // An empty packet skips payload entirely and goes straight to the trailer
  assign zero_len  = (state_q == PAYLOAD) && (cnt_q == '0) && (len_clamp == '0);

  // Hold the packet length for the remainder of the packet once its first word is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
    end else if (in_xfer && (cnt_q == '0)) begin
      len_q <= len_clamp;
    end
  end
`else
  assign last_word = (cnt_q == CntW'(PacketWords - 1));
  assign zero_len  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAYLOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload word counter; cleared at the end of each packet so the next starts at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (in_xfer) begin
      if (last_word) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Next-state: FLUSH is a single unconditional cycle, trailer words advance on accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      PAYLOAD: begin
        if (zero_len || (in_xfer && last_word)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = TRAIL_HI;
      end
      TRAIL_HI: begin
        if (out_ready) begin
          state_d = TRAIL_LO;
        end
      end
      TRAIL_LO: begin
        if (out_ready) begin
          state_d = PAYLOAD;
        end
      end
      default: begin
        state_d = PAYLOAD;
      end
    endcase
  end

  // Outputs: pass-through in payload, one zero enable to settle the B sum, then the
  // trailer straight from the engine's registered result
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    ck_en     = 1'b0;
    ck_din    = '0;
    case (state_q)
      PAYLOAD: begin
        if (!zero_len) begin
          out_valid = in_valid;
          in_ready  = out_ready;
          out_data  = in_data;
          ck_din    = in_data;
          ck_en     = in_valid && out_ready;
        end
      end
      FLUSH: begin
        ck_en = 1'b1;
      end
      TRAIL_HI: begin
        out_valid = 1'b1;
        out_data  = ck_dout[Width-1:WidthHalf];
      end
      TRAIL_LO: begin
        out_valid = 1'b1;
        out_data  = ck_dout[WidthHalf-1:0];
        out_last  = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
    if (rst) begin
      out_valid = 1'b0;
      in_ready  = 1'b0;
      ck_en     = 1'b0;
    end
  end

  // Clear the engine on reset and as the final trailer word leaves, ready for the next packet
  assign ck_rst = rst || ((state_q == TRAIL_LO) && out_xfer);

endmodule

// File: tb/tb_checksum_trailer_appender.sv
`timescale 1ns/1ps
module tb_checksum_trailer_appender;

  localparam int W  = 16;
  localparam int PW = 2;
  localparam int H  = 8;
  localparam int CW = $clog2(PW + 1);

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
    logic       trl;
  } exp_t;

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [H-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [H-1:0] out_data;
  logic         out_last;
  logic         ck_rst;
  logic         ck_en;
  logic [H-1:0] ck_din;
  logic [W-1:0] ck_dout;
`ifdef CHECKSUM_TRAILER_LEN_EN
  logic [CW-1:0] pkt_len;
`endif

  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic bp_mode = 1'b0;

  always #5 clk = ~clk;

  checksum_trailer_appender #(.Width(W), .PacketWords(PW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CHECKSUM_TRAILER_LEN_EN
    .pkt_len   (pkt_len),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .ck_rst    (ck_rst),
    .ck_en     (ck_en),
    .ck_din    (ck_din),
    .ck_dout   (ck_dout)
  );

  // Behavioural Fletcher engine: B accumulates the previous A, so it lags by one enable
  logic [7:0] eng_a = 8'h00;
  logic [7:0] eng_b = 8'h00;
  always @(posedge clk) begin
    if (ck_rst) begin
      eng_a <= 8'h00;
      eng_b <= 8'h00;
    end else if (ck_en) begin
      eng_b <= 8'((int'(eng_b) + int'(eng_a)) % 255);
      eng_a <= 8'((int'(eng_a) + int'(ck_din)) % 255);
    end
  end
  assign ck_dout = {eng_b, eng_a};

  // Reference Fletcher-16 over a two-word packet, returns {B, A}
  function automatic logic [15:0] fl2(input logic [7:0] w0, input logic [7:0] w1);
    int a;
    int b;
    a = 0;
    b = 0;
    a = (a + int'(w0)) % 255;
    b = (b + a) % 255;
    a = (a + int'(w1)) % 255;
    b = (b + a) % 255;
    return {8'(b), 8'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Random downstream stalls when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor: no intake while a trailer is pending, then scoreboard compare
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0 && exp_q[0].trl) begin
      checks++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL in_ready_in_trailer actual=%b required=0", in_ready);
      end
    end
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out actual=%h/%b required=none", out_data, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_data !== mon_e.dat || out_last !== mon_e.last) begin
          fails++;
          $display("FAIL out_word actual=%h/%b required=%h/%b", out_data, out_last, mon_e.dat, mon_e.last);
        end
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input int gap, output int waits);
    logic done;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 200) begin
          checks++;
          fails++;
          $display("FAIL send_timeout actual=stalled required=accept");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] hi, input logic [7:0] lo,
                          input int gap, output int waits_first);
    int w;
    exp_q.push_back('{dat: w0, last: 1'b0, trl: 1'b0});
    exp_q.push_back('{dat: w1, last: 1'b0, trl: 1'b0});
    exp_q.push_back('{dat: hi, last: 1'b0, trl: 1'b1});
    exp_q.push_back('{dat: lo, last: 1'b1, trl: 1'b1});
    send_word(w0, gap, waits_first);
    send_word(w1, gap, w);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   wf;
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [15:0] ref_ck;

    vecs[0] = '{w0: 8'h01, w1: 8'h02, hi: 8'h04, lo: 8'h03};
    vecs[1] = '{w0: 8'hFF, w1: 8'hFF, hi: 8'h00, lo: 8'h00};
    vecs[2] = '{w0: 8'h01, w1: 8'h02, hi: 8'h04, lo: 8'h03};
    vecs[3] = '{w0: 8'h10, w1: 8'h20, hi: 8'h40, lo: 8'h30};
    vecs[4] = '{w0: 8'h80, w1: 8'h90, hi: 8'h91, lo: 8'h11};

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b1;
`ifdef CHECKSUM_TRAILER_LEN_EN
    pkt_len   = CW'(2);
`endif

    // Reset state, with in_valid and out_ready high to expose ungated pass-through
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ck_en", 32'(ck_en), 32'd0);
    chk("rst_ck_rst", 32'(ck_rst), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;

    // Basic packet: one idle FLUSH cycle between payload and trailer
    send_pkt(8'h01, 8'h02, 8'h04, 8'h03, 0, wf);
    @(negedge clk);
    chk("flush_idle_out_valid", 32'(out_valid), 32'd0);
    chk("flush_ck_en", 32'(ck_en), 32'd1);
    wait_drain();

    // Table-driven packets back to back: next packet enters right after TRAIL_LO accept
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      send_pkt(vecs[i].w0, vecs[i].w1, vecs[i].hi, vecs[i].lo, 0, wf);
      if (i > 0) chk("b2b_first_word_wait", 32'(wf), 32'd3);
    end
    wait_drain();

    // Trailer stall: hi word held and engine frozen for 5 cycles
    @(posedge clk);
    #1;
    send_pkt(8'h01, 8'h02, 8'h04, 8'h03, 0, wf);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", 32'(out_data), 32'h04);
      chk("stall_ck_en", 32'(ck_en), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // Reset after the first payload word: partial packet dropped, no trailer
    @(posedge clk);
    #1;
    exp_q.push_back('{dat: 8'h01, last: 1'b0, trl: 1'b0});
    send_word(8'h01, 0, wf);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_ck_rst", 32'(ck_rst), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_trailer_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    send_pkt(8'h01, 8'h02, 8'h04, 8'h03, 0, wf);
    wait_drain();

    // Random data, input gaps and downstream stalls over 100 packets
    @(posedge clk);
    #1;
    bp_mode = 1'b1;
    for (int p = 0; p < 100; p++) begin
      r0     = 8'($urandom_range(0, 255));
      r1     = 8'($urandom_range(0, 255));
      ref_ck = fl2(r0, r1);
      send_pkt(r0, r1, ref_ck[15:8], ref_ck[7:0], int'($urandom_range(0, 2)), wf);
    end
    wait_drain();
    bp_mode   = 1'b0;
    out_ready = 1'b1;

`ifdef CHECKSUM_TRAILER_LEN_EN
    // Empty packet: trailer only, all zero
    @(posedge clk);
    #1;
    exp_q.push_back('{dat: 8'h00, last: 1'b0, trl: 1'b1});
    exp_q.push_back('{dat: 8'h00, last: 1'b1, trl: 1'b1});
    pkt_len = CW'(0);
    @(posedge clk);
    #1;
    pkt_len = CW'(2);
    wait_drain();

    // Single-word packet
    @(posedge clk);
    #1;
    pkt_len = CW'(1);
    exp_q.push_back('{dat: 8'h05, last: 1'b0, trl: 1'b0});
    exp_q.push_back('{dat: 8'h05, last: 1'b0, trl: 1'b1});
    exp_q.push_back('{dat: 8'h05, last: 1'b1, trl: 1'b1});
    send_word(8'h05, 0, wf);
    pkt_len = CW'(2);
    wait_drain();

    // Oversized length clamps to the maximum
    @(posedge clk);
    #1;
    pkt_len = CW'(3);
    send_pkt(8'h01, 8'h02, 8'h04, 8'h03, 0, wf);
    pkt_len = CW'(2);
    wait_drain();
`endif

    repeat (4) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
